tlb_victim_sel: RTL
===================

Name: tlb_victim_sel

Overview:
- Parametrised TLB replacement-victim selector for the BIU/MMU.
- Tracks a saturating access counter per entry internally, with global aging when a counter saturates.
- On request, snapshots entry state and picks one victim by a fixed priority through a comparator tree.
- Holds the registered result on a valid/ready handshake until the refill engine consumes it.

Parameters:
ENTRIES, 8, number of TLB entries; power of 2, ≥2
CNT_W, 12, access-counter width
ID_W, $clog2(ENTRIES), victim index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
entry_valid_i  in  ENTRIES  per-entry TLB valid
entry_g_i  in  ENTRIES  per-entry PTE.G (global)
lock_i  in  ENTRIES  pinned entries, never chosen
hit_i  in  ENTRIES  per-entry hit this cycle; multi-hot allowed (I+D ports)
fill_i  in  ENTRIES  entry being refilled this cycle; clears its counter
flush_i  in  1  clears all counters
sel_req_i  in  1  victim request (level)
sel_vld_o  out  1  victim result valid
sel_rdy_i  in  1  consumer accepts result
sel_id_o  out  ID_W  victim index
sel_none_o  out  1  all entries locked; sel_id_o meaningless

Behaviour:
- Reset values: all counters 0; FSM IDLE; sel_vld_o=0; sel_id_o=0; sel_none_o=0.
- Counter update, every cycle, in this priority order:
  - flush_i: all counters become 0; hit/fill ignored that cycle.
  - Otherwise, aging: if any entry has hit_i=1 and counter = 2^CNT_W-1, every counter becomes (old>>1); each hit entry is then +1.
  - Otherwise, each hit entry increments by 1 and other entries hold.
  - fill_i[k] forces counter[k]=0 and overrides a hit on the same entry in the same cycle.
- Selection key per unlocked entry: {entry_valid, entry_g, counter}, compared unsigned.
  - Minimum key wins: invalid before valid, then non-global before global, then lowest count.
  - Equal keys resolve to the lower index.
  - Locked entries are excluded.
  - If all entries are locked: sel_none_o=1 and sel_id_o=0.
- FSM states and transitions:
  - IDLE: on sel_req_i=1, capture entry_valid_i/entry_g_i/lock_i and the post-update counters of this cycle into snapshot registers; go to CALC.
  - CALC: evaluate the comparator tree over the snapshot; register sel_id_o/sel_none_o; set sel_vld_o=1; go to HOLD.
  - HOLD: outputs stable while sel_vld_o=1. When sel_rdy_i=1, clear sel_vld_o and go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency: request accepted in cycle T gives sel_vld_o=1 in cycle T+2. Back-to-back requests give one result per 3 cycles minimum.
- Counters keep updating in CALC and HOLD; results always reflect the snapshot, never live state.
- sel_req_i dropping after acceptance does not abort the transaction.
- flush_i during CALC/HOLD does not change the pending result.
- rst at any point: return to IDLE, drop sel_vld_o the next cycle, clear counters; no result is produced for an in-flight request.

Decomposition:
- Package tlb_repl_pkg:
  - key-width constant (CNT_W+2);
  - fsm state enum {IDLE, CALC, HOLD};
  - packed key struct {valid, g, cnt}.
- Sub-module victim_cmp_cell: purely combinational 2-input node taking (id, lock, key) ×2 and passing on the winner plus an all-locked flag.
  - Instantiated log2(ENTRIES) levels deep via generate.
  - At equal keys it passes the lower index.

Test Plan:
- Reset, then ENTRIES=8 all valid, G=0, counters 0, sel_req_i pulse → sel_vld_o=1 exactly 2 cycles later, sel_id_o=0; holds with sel_rdy_i=0 for 5 cycles; drops the cycle after sel_rdy_i=1.
- entry_valid_i=8'hFF except bit5=0, entry 2 has 0 hits → sel_id_o=5. Then all valid with entry_g_i=8'hF7 → sel_id_o=3.
- All valid non-global; hit entries 0..7 with counts {4,4,1,9,1,3,7,2} → sel_id_o=2 (tie with 4 broken to the lower index). Then lock_i=8'h04 → sel_id_o=4.
- CNT_W=4 build: entry1 at 15, entry0 at 6, hit_i=8'h02 → next cycle entry1=8, entry0=3.
  - hit_i[4] and fill_i[4] in the same cycle → counter4=0.
  - flush_i → all counters 0.
- lock_i=8'hFF with request → sel_none_o=1, sel_id_o=0. Separately, assert rst in CALC → sel_vld_o never rises and the FSM is back in IDLE.

Source files
------------

// File: rtl/tlb_repl_pkg.sv
// Shared types and constants for the TLB replacement-victim selector.
// The selection key is {valid, g, cnt}; the lowest key is the preferred victim.
package tlb_repl_pkg;

    localparam int KEY_EXTRA_W = 2;
    localparam int DEF_CNT_W   = 12;
    localparam int KEY_W       = DEF_CNT_W + KEY_EXTRA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 g;
        logic [DEF_CNT_W-1:0] cnt;
    } key_t;

    function automatic int key_width(input int cnt_w);
        return cnt_w + KEY_EXTRA_W;
    endfunction

endpackage

// File: rtl/victim_cmp_cell.sv
// One node of the victim comparator tree: passes on the unlocked input with the
// smaller key; input a wins ties, so wiring a to the lower-index side keeps index order.
module victim_cmp_cell #(
    parameter int ID_W  = 3,
    parameter int KEY_W = 14
) (
    input  logic [ID_W-1:0]  a_id,
    input  logic             a_lock,
    input  logic [KEY_W-1:0] a_key,
    input  logic [ID_W-1:0]  b_id,
    input  logic             b_lock,
    input  logic [KEY_W-1:0] b_key,
    output logic [ID_W-1:0]  win_id,
    output logic             win_lock,
    output logic [KEY_W-1:0] win_key
);

    logic take_b;

    always_comb begin
        take_b   = !b_lock && (a_lock || (b_key < a_key));
        win_id   = take_b ? b_id  : a_id;
        win_key  = take_b ? b_key : a_key;
        win_lock = a_lock & b_lock;
    end

endmodule

// File: rtl/tlb_victim_sel.sv
// TLB replacement-victim selector: per-entry saturating access counters with
// global aging, snapshot on request, comparator-tree pick, valid/ready result hold.
module tlb_victim_sel
    import tlb_repl_pkg::*;
#(
    parameter  int ENTRIES = 8,
    parameter  int CNT_W   = 12,
    localparam int ID_W    = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] entry_valid_i,
    input  logic [ENTRIES-1:0] entry_g_i,
    input  logic [ENTRIES-1:0] lock_i,
    input  logic [ENTRIES-1:0] hit_i,
    input  logic [ENTRIES-1:0] fill_i,
    input  logic               flush_i,
    input  logic               sel_req_i,
    output logic               sel_vld_o,
    input  logic               sel_rdy_i,
    output logic [ID_W-1:0]    sel_id_o,
    output logic               sel_none_o,
    output logic [1:0]         dbg_state
);

    // Handshake: the result is transferred in a cycle where sel_vld_o and
    // sel_rdy_i are both 1; while sel_vld_o is 1 the result does not change.

    localparam int              K_W      = key_width(CNT_W);
    localparam int              NODES    = 2 * ENTRIES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_CALC  = CALC;
    localparam logic [1:0]      ST_HOLD  = HOLD;

    logic [1:0]         state_q;
    logic [CNT_W-1:0]   cnt_q     [ENTRIES];
    logic [CNT_W-1:0]   cnt_nxt   [ENTRIES];
    logic               any_sat;
    logic [ENTRIES-1:0] snap_valid;
    logic [ENTRIES-1:0] snap_g;
    logic [ENTRIES-1:0] snap_lock;
    logic [CNT_W-1:0]   snap_cnt  [ENTRIES];

    logic [ID_W-1:0]    node_id   [NODES];
    logic               node_lock [NODES];
    logic [K_W-1:0]     node_key  [NODES];

    assign dbg_state = state_q;

    // Aging halves every counter before the hit increment, so a saturated
    // entry that hits lands at (MAX>>1)+1 and can never wrap.
    always_comb begin
        any_sat = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (hit_i[k] && (cnt_q[k] == CNT_MAX)) any_sat = 1'b1;
        end
        for (int k = 0; k < ENTRIES; k++) begin
            cnt_nxt[k] = cnt_q[k];
            if (flush_i) begin
                cnt_nxt[k] = '0;
            end else begin
                if (any_sat)   cnt_nxt[k] = cnt_q[k] >> 1;
                if (hit_i[k])  cnt_nxt[k] = cnt_nxt[k] + CNT_W'(1);
                if (fill_i[k]) cnt_nxt[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < ENTRIES; k++) cnt_q[k] <= cnt_nxt[k];
        end
    end

    // Heap-ordered tree: node n has children 2n+1 (lower indices) and 2n+2.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_leaf
        assign node_id[ENTRIES-1+i]   = ID_W'(i);
        assign node_lock[ENTRIES-1+i] = snap_lock[i];
        assign node_key[ENTRIES-1+i]  = {snap_valid[i], snap_g[i], snap_cnt[i]};
    end

    for (genvar n = 0; n < ENTRIES - 1; n++) begin : g_node
        victim_cmp_cell #(
            .ID_W  (ID_W),
            .KEY_W (K_W)
        ) u_cell (
            .a_id     (node_id[2*n+1]),
            .a_lock   (node_lock[2*n+1]),
            .a_key    (node_key[2*n+1]),
            .b_id     (node_id[2*n+2]),
            .b_lock   (node_lock[2*n+2]),
            .b_key    (node_key[2*n+2]),
            .win_id   (node_id[n]),
            .win_lock (node_lock[n]),
            .win_key  (node_key[n])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_vld_o  <= 1'b0;
            sel_id_o   <= '0;
            sel_none_o <= 1'b0;
            snap_valid <= '0;
            snap_g     <= '0;
            snap_lock  <= '0;
            for (int k = 0; k < ENTRIES; k++) snap_cnt[k] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_req_i) begin
                        snap_valid <= entry_valid_i;
                        snap_g     <= entry_g_i;
                        snap_lock  <= lock_i;
                        for (int k = 0; k < ENTRIES; k++) snap_cnt[k] <= cnt_nxt[k];
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    sel_none_o <= node_lock[0];
                    sel_id_o   <= node_lock[0] ? '0 : node_id[0];
                    sel_vld_o  <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (sel_rdy_i) begin
                        sel_vld_o <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    sel_vld_o <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
